// File: rtl/pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// pipe_stage_chain
// Parametrised chain of DEPTH pipeline registers, each stage carrying a
// WIDTH-bit payload plus its own valid bit. It supports a global freeze from
// the hazard unit, a branch flush of the leading FLUSH_DEPTH stages, and
// ready/valid back-pressure from the consumer. With COLLAPSE=1 the chain is
// elastic: upstream stages keep filling bubbles while the output is stalled.
// With COLLAPSE=0 every stage moves in lock-step.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   producer offers in_data
//   in_data    payload entering stage 0
//   in_ready   chain accepts this cycle (combinational)
//   freeze     hold request from the hazard unit
//   flush      discard wrong-path contents of stages 0..FLUSH_DEPTH-1
//   out_valid  valid bit of the last stage (registered)
//   out_data   payload of the last stage (registered)
//   out_ready  consumer accepts this cycle
//   occupancy  number of valid stages (registered)
// ---------------------------------------------------------------------------
module pipe_stage_chain #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int FLUSH_DEPTH = 1,
    parameter int COLLAPSE    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       freeze,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] adv;
    logic             stall_out;
    logic             flush_en;
    logic             in_xfer;

    // With FLUSH_DEPTH=0 there is nothing to flush, so the port is inert.
    assign flush_en = (FLUSH_DEPTH > 0) && flush;

    // Readiness ripples from the consumer back toward stage 0. In the
    // elastic chain an empty stage is always ready; in lock-step mode a
    // stalled output stops every stage at once.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        stall_out  = v_q[DEPTH-1] & ~rdy[DEPTH];
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (COLLAPSE != 0) begin
                rdy[k] = ~v_q[k] | rdy[k+1];
            end else begin
                rdy[k] = ~stall_out;
            end
        end
        adv = rdy[DEPTH-1:0] & {DEPTH{~freeze}};
    end

    always_comb begin
        logic inc;
        inc      = 1'b0;
        v_d      = v_q;
        data_d   = data_q;
        in_xfer  = in_valid & adv[0] & ~flush_en;
        // During flush the input is swallowed even if the chain is frozen.
        in_ready = adv[0] | flush_en;

        if (flush_en) begin
            v_d[0] = 1'b0;
        end else if (adv[0]) begin
            v_d[0] = in_xfer;
            if (in_xfer) begin
                data_d[0] = in_data;
            end
        end

        for (int k = 1; k < DEPTH; k++) begin
            if (flush_en && (k < FLUSH_DEPTH)) begin
                v_d[k] = 1'b0;
            end else if (adv[k]) begin
                // The first surviving stage takes a bubble instead of the
                // wrong-path word sitting in front of it.
                inc    = v_q[k-1] & ~(flush_en && (k == FLUSH_DEPTH));
                v_d[k] = inc;
                if (inc) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end

        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(v_d[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            occ_q  <= occ_d;
            data_q <= data_d;
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_chain
// Drives an elastic (COLLAPSE=1) and a lock-step (COLLAPSE=0) chain, both
// DEPTH=4 / FLUSH_DEPTH=1, from the same stimulus and compares their outputs
// against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_pipe_stage_chain;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         freeze = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;

    logic         in_ready_c, out_valid_c;
    logic [W-1:0] out_data_c;
    logic [2:0]   occ_c;
    logic         in_ready_l, out_valid_l;
    logic [W-1:0] out_data_l;
    logic [2:0]   occ_l;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .FLUSH_DEPTH(1), .COLLAPSE(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_c), .freeze(freeze), .flush(flush),
        .out_valid(out_valid_c), .out_data(out_data_c), .out_ready(out_ready),
        .occupancy(occ_c)
    );

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .FLUSH_DEPTH(1), .COLLAPSE(0)) u_dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_l), .freeze(freeze), .flush(flush),
        .out_valid(out_valid_l), .out_data(out_data_l), .out_ready(out_ready),
        .occupancy(occ_l)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        freeze    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (out_valid_c !== 1'b0) $display("FAIL reset_out_valid_c got=%0b want=0", out_valid_c); else n_pass++;
        n_total++; if (out_valid_l !== 1'b0) $display("FAIL reset_out_valid_l got=%0b want=0", out_valid_l); else n_pass++;
        n_total++; if (out_data_c !== 32'h0) $display("FAIL reset_out_data_c got=%h want=0", out_data_c); else n_pass++;
        n_total++; if (out_data_l !== 32'h0) $display("FAIL reset_out_data_l got=%h want=0", out_data_l); else n_pass++;
        n_total++; if (occ_c !== 3'd0) $display("FAIL reset_occ_c got=%0d want=0", occ_c); else n_pass++;
        n_total++; if (occ_l !== 3'd0) $display("FAIL reset_occ_l got=%0d want=0", occ_l); else n_pass++;
        n_total++; if (in_ready_c !== 1'b1) $display("FAIL reset_in_ready_c got=%0b want=1", in_ready_c); else n_pass++;
        n_total++; if (in_ready_l !== 1'b1) $display("FAIL reset_in_ready_l got=%0b want=1", in_ready_l); else n_pass++;
    endtask

    // Continuous stream: first word visible after the 4th accepting edge.
    task automatic test_stream();
        logic         ev;
        logic [W-1:0] ed;
        logic [2:0]   eo;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int e = 0; e < 10; e++) begin
            in_data = 32'h1000 + 32'(4 * e);
            step();
            ev = (e >= 3);
            ed = (e >= 3) ? 32'h1000 + 32'(4 * (e - 3)) : 32'h0;
            eo = (e >= 3) ? 3'd4 : 3'(e + 1);
            n_total++; if (out_valid_c !== ev || (ev && out_data_c !== ed)) $display("FAIL stream_out_c e=%0d got v=%0b d=%h want v=%0b d=%h", e, out_valid_c, out_data_c, ev, ed); else n_pass++;
            n_total++; if (out_valid_l !== ev || (ev && out_data_l !== ed)) $display("FAIL stream_out_l e=%0d got v=%0b d=%h want v=%0b d=%h", e, out_valid_l, out_data_l, ev, ed); else n_pass++;
            n_total++; if (occ_c !== eo) $display("FAIL stream_occ_c e=%0d got=%0d want=%0d", e, occ_c, eo); else n_pass++;
            n_total++; if (occ_l !== eo) $display("FAIL stream_occ_l e=%0d got=%0d want=%0d", e, occ_l, eo); else n_pass++;
        end
    endtask

    // Full chain with out_ready low for three cycles, then resume.
    task automatic test_backpressure();
        int           nxt;
        logic [W-1:0] ed;
        do_reset();
        in_valid = 1'b1;
        for (int e = 0; e < 4; e++) begin
            in_data = 32'h3000 + 32'(4 * e);
            step();
        end
        n_total++; if (occ_c !== 3'd4) $display("FAIL bp_full_occ_c got=%0d want=4", occ_c); else n_pass++;
        n_total++; if (occ_l !== 3'd4) $display("FAIL bp_full_occ_l got=%0d want=4", occ_l); else n_pass++;
        in_data = 32'h3010;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_total++; if (in_ready_c !== 1'b0) $display("FAIL bp_in_ready_c c=%0d got=%0b want=0", c, in_ready_c); else n_pass++;
            n_total++; if (in_ready_l !== 1'b0) $display("FAIL bp_in_ready_l c=%0d got=%0b want=0", c, in_ready_l); else n_pass++;
            step();
            n_total++; if (out_valid_c !== 1'b1 || out_data_c !== 32'h3000) $display("FAIL bp_hold_c c=%0d got v=%0b d=%h want v=1 d=3000", c, out_valid_c, out_data_c); else n_pass++;
            n_total++; if (out_valid_l !== 1'b1 || out_data_l !== 32'h3000) $display("FAIL bp_hold_l c=%0d got v=%0b d=%h want v=1 d=3000", c, out_valid_l, out_data_l); else n_pass++;
            n_total++; if (occ_c !== 3'd4 || occ_l !== 3'd4) $display("FAIL bp_hold_occ c=%0d got c=%0d l=%0d want 4", c, occ_c, occ_l); else n_pass++;
        end
        out_ready = 1'b1;
        nxt = 4;
        for (int e = 0; e < 5; e++) begin
            in_data = 32'h3000 + 32'(4 * nxt);
            #1;
            n_total++; if (in_ready_c !== 1'b1 || in_ready_l !== 1'b1) $display("FAIL bp_resume_in_ready e=%0d got c=%0b l=%0b want 1", e, in_ready_c, in_ready_l); else n_pass++;
            step();
            nxt++;
            ed = 32'h3000 + 32'(4 * (nxt - 4));
            n_total++; if (out_valid_c !== 1'b1 || out_data_c !== ed) $display("FAIL bp_resume_c e=%0d got v=%0b d=%h want v=1 d=%h", e, out_valid_c, out_data_c, ed); else n_pass++;
            n_total++; if (out_valid_l !== 1'b1 || out_data_l !== ed) $display("FAIL bp_resume_l e=%0d got v=%0b d=%h want v=1 d=%h", e, out_valid_l, out_data_l, ed); else n_pass++;
            n_total++; if (occ_c !== 3'd4 || occ_l !== 3'd4) $display("FAIL bp_resume_occ e=%0d got c=%0d l=%0d want 4", e, occ_c, occ_l); else n_pass++;
        end
    endtask

    // Bubble in stage 1 while the output is stalled: only the elastic chain fills it.
    task automatic test_bubble_collapse();
        logic [W:0] exp_c [4];
        logic [W:0] exp_l [4];
        exp_c = '{33'h1_0000_7004, 33'h1_0000_7008, 33'h1_0000_700C, 33'h0_0000_0000};
        exp_l = '{33'h1_0000_7004, 33'h0_0000_0000, 33'h1_0000_7008, 33'h0_0000_0000};
        do_reset();
        in_valid = 1'b1; in_data = 32'h7000; step();
        in_data = 32'h7004; step();
        in_valid = 1'b0; step();
        in_valid = 1'b1; in_data = 32'h7008; step();
        n_total++; if (occ_c !== 3'd3 || occ_l !== 3'd3) $display("FAIL bub_occ_before got c=%0d l=%0d want 3", occ_c, occ_l); else n_pass++;
        n_total++; if (out_valid_c !== 1'b1 || out_data_c !== 32'h7000) $display("FAIL bub_out_c got v=%0b d=%h want v=1 d=7000", out_valid_c, out_data_c); else n_pass++;
        in_data = 32'h700C;
        #1;
        n_total++; if (in_ready_c !== 1'b1) $display("FAIL bub_in_ready_c got=%0b want=1", in_ready_c); else n_pass++;
        n_total++; if (in_ready_l !== 1'b0) $display("FAIL bub_in_ready_l got=%0b want=0", in_ready_l); else n_pass++;
        step();
        n_total++; if (occ_c !== 3'd4) $display("FAIL bub_occ_c got=%0d want=4", occ_c); else n_pass++;
        n_total++; if (occ_l !== 3'd3) $display("FAIL bub_occ_l got=%0d want=3", occ_l); else n_pass++;
        n_total++; if (out_valid_l !== 1'b1 || out_data_l !== 32'h7000) $display("FAIL bub_hold_l got v=%0b d=%h want v=1 d=7000", out_valid_l, out_data_l); else n_pass++;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int e = 0; e < 4; e++) begin
            step();
            n_total++; if (out_valid_c !== exp_c[e][W] || (exp_c[e][W] && out_data_c !== exp_c[e][W-1:0])) $display("FAIL bub_drain_c e=%0d got v=%0b d=%h want v=%0b d=%h", e, out_valid_c, out_data_c, exp_c[e][W], exp_c[e][W-1:0]); else n_pass++;
            n_total++; if (out_valid_l !== exp_l[e][W] || (exp_l[e][W] && out_data_l !== exp_l[e][W-1:0])) $display("FAIL bub_drain_l e=%0d got v=%0b d=%h want v=%0b d=%h", e, out_valid_l, out_data_l, exp_l[e][W], exp_l[e][W-1:0]); else n_pass++;
        end
    endtask

    // Two-cycle freeze mid-stream with out_ready high.
    task automatic test_freeze();
        int           nxt;
        logic         frz;
        logic         ev;
        logic [W-1:0] ed;
        logic [2:0]   eo;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        nxt = 0;
        for (int e = 0; e < 12; e++) begin
            frz     = (e == 6) || (e == 7);
            freeze  = frz;
            in_data = 32'h4000 + 32'(4 * nxt);
            #1;
            n_total++; if (in_ready_c !== ~frz || in_ready_l !== ~frz) $display("FAIL frz_in_ready e=%0d got c=%0b l=%0b want %0b", e, in_ready_c, in_ready_l, ~frz); else n_pass++;
            step();
            if (!frz) nxt++;
            ev = (nxt >= 4);
            ed = ev ? 32'h4000 + 32'(4 * (nxt - 4)) : 32'h0;
            eo = (nxt >= 4) ? 3'd4 : 3'(nxt);
            n_total++; if (out_valid_c !== ev || (ev && out_data_c !== ed)) $display("FAIL frz_out_c e=%0d got v=%0b d=%h want v=%0b d=%h", e, out_valid_c, out_data_c, ev, ed); else n_pass++;
            n_total++; if (out_valid_l !== ev || (ev && out_data_l !== ed)) $display("FAIL frz_out_l e=%0d got v=%0b d=%h want v=%0b d=%h", e, out_valid_l, out_data_l, ev, ed); else n_pass++;
            n_total++; if (occ_c !== eo || occ_l !== eo) $display("FAIL frz_occ e=%0d got c=%0d l=%0d want %0d", e, occ_c, occ_l, eo); else n_pass++;
        end
        freeze = 1'b0;
    endtask

    // Flush of stage 0 while it holds 0x2008 and 0x200C is offered.
    task automatic test_flush();
        logic [W:0] exp_o [5];
        logic [2:0] exp_n [5];
        exp_o = '{33'h1_0000_2004, 33'h0, 33'h0, 33'h1_0000_2010, 33'h0};
        exp_n = '{3'd2, 3'd1, 3'd1, 3'd1, 3'd0};
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int e = 0; e < 3; e++) begin
            in_data = 32'h2000 + 32'(4 * e);
            step();
        end
        n_total++; if (occ_c !== 3'd3 || occ_l !== 3'd3) $display("FAIL fl_occ_pre got c=%0d l=%0d want 3", occ_c, occ_l); else n_pass++;
        in_data = 32'h200C;
        flush   = 1'b1;
        #1;
        n_total++; if (in_ready_c !== 1'b1 || in_ready_l !== 1'b1) $display("FAIL fl_in_ready got c=%0b l=%0b want 1", in_ready_c, in_ready_l); else n_pass++;
        step();
        flush = 1'b0;
        n_total++; if (occ_c !== 3'd2 || occ_l !== 3'd2) $display("FAIL fl_occ_post got c=%0d l=%0d want 2", occ_c, occ_l); else n_pass++;
        n_total++; if (out_valid_c !== 1'b1 || out_data_c !== 32'h2000) $display("FAIL fl_out0_c got v=%0b d=%h want v=1 d=2000", out_valid_c, out_data_c); else n_pass++;
        in_data = 32'h2010;
        for (int e = 0; e < 5; e++) begin
            step();
            in_valid = 1'b0;
            n_total++; if (out_valid_c !== exp_o[e][W] || (exp_o[e][W] && out_data_c !== exp_o[e][W-1:0])) $display("FAIL fl_drain_c e=%0d got v=%0b d=%h want v=%0b d=%h", e, out_valid_c, out_data_c, exp_o[e][W], exp_o[e][W-1:0]); else n_pass++;
            n_total++; if (out_valid_l !== exp_o[e][W] || (exp_o[e][W] && out_data_l !== exp_o[e][W-1:0])) $display("FAIL fl_drain_l e=%0d got v=%0b d=%h want v=%0b d=%h", e, out_valid_l, out_data_l, exp_o[e][W], exp_o[e][W-1:0]); else n_pass++;
            n_total++; if (occ_c !== exp_n[e] || occ_l !== exp_n[e]) $display("FAIL fl_drain_occ e=%0d got c=%0d l=%0d want %0d", e, occ_c, occ_l, exp_n[e]); else n_pass++;
        end
    endtask

    // Flush together with freeze: stage 0 clears, stages 1..2 hold.
    task automatic test_flush_freeze();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int e = 0; e < 3; e++) begin
            in_data = 32'h5000 + 32'(4 * e);
            step();
        end
        flush   = 1'b1;
        freeze  = 1'b1;
        in_data = 32'h500C;
        #1;
        n_total++; if (in_ready_c !== 1'b1 || in_ready_l !== 1'b1) $display("FAIL ff_in_ready got c=%0b l=%0b want 1", in_ready_c, in_ready_l); else n_pass++;
        step();
        flush    = 1'b0;
        freeze   = 1'b0;
        in_valid = 1'b0;
        n_total++; if (occ_c !== 3'd2 || occ_l !== 3'd2) $display("FAIL ff_occ got c=%0d l=%0d want 2", occ_c, occ_l); else n_pass++;
        n_total++; if (out_valid_c !== 1'b0 || out_valid_l !== 1'b0) $display("FAIL ff_out_valid got c=%0b l=%0b want 0", out_valid_c, out_valid_l); else n_pass++;
        step();
        n_total++; if (out_valid_c !== 1'b1 || out_data_c !== 32'h5000 || occ_c !== 3'd2) $display("FAIL ff_drain0_c got v=%0b d=%h o=%0d want v=1 d=5000 o=2", out_valid_c, out_data_c, occ_c); else n_pass++;
        n_total++; if (out_valid_l !== 1'b1 || out_data_l !== 32'h5000 || occ_l !== 3'd2) $display("FAIL ff_drain0_l got v=%0b d=%h o=%0d want v=1 d=5000 o=2", out_valid_l, out_data_l, occ_l); else n_pass++;
        step();
        n_total++; if (out_valid_c !== 1'b1 || out_data_c !== 32'h5004 || occ_c !== 3'd1) $display("FAIL ff_drain1_c got v=%0b d=%h o=%0d want v=1 d=5004 o=1", out_valid_c, out_data_c, occ_c); else n_pass++;
        n_total++; if (out_valid_l !== 1'b1 || out_data_l !== 32'h5004 || occ_l !== 3'd1) $display("FAIL ff_drain1_l got v=%0b d=%h o=%0d want v=1 d=5004 o=1", out_valid_l, out_data_l, occ_l); else n_pass++;
        step();
        n_total++; if (out_valid_c !== 1'b0 || occ_c !== 3'd0 || out_valid_l !== 1'b0 || occ_l !== 3'd0) $display("FAIL ff_empty got vc=%0b oc=%0d vl=%0b ol=%0d want 0", out_valid_c, occ_c, out_valid_l, occ_l); else n_pass++;
    endtask

    // Asynchronous reset between edges with three words in flight.
    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int e = 0; e < 3; e++) begin
            in_data = 32'h6000 + 32'(4 * e);
            step();
        end
        in_valid = 1'b0;
        step();
        n_total++; if (occ_c !== 3'd3 || occ_l !== 3'd3) $display("FAIL ar_occ_pre got c=%0d l=%0d want 3", occ_c, occ_l); else n_pass++;
        n_total++; if (out_valid_c !== 1'b1 || out_data_c !== 32'h6000) $display("FAIL ar_out_pre_c got v=%0b d=%h want v=1 d=6000", out_valid_c, out_data_c); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++; if (out_valid_c !== 1'b0 || out_valid_l !== 1'b0) $display("FAIL ar_out_valid got c=%0b l=%0b want 0", out_valid_c, out_valid_l); else n_pass++;
        n_total++; if (occ_c !== 3'd0 || occ_l !== 3'd0) $display("FAIL ar_occ got c=%0d l=%0d want 0", occ_c, occ_l); else n_pass++;
        n_total++; if (out_data_c !== 32'h0 || out_data_l !== 32'h0) $display("FAIL ar_out_data got c=%h l=%h want 0", out_data_c, out_data_l); else n_pass++;
        @(posedge clk);
        #3;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h6100;
        for (int e = 0; e < 4; e++) begin
            step();
            in_valid = 1'b0;
            if (e < 3) begin
                n_total++; if (out_valid_c !== 1'b0 || out_valid_l !== 1'b0) $display("FAIL ar_lat e=%0d got c=%0b l=%0b want 0", e, out_valid_c, out_valid_l); else n_pass++;
            end else begin
                n_total++; if (out_valid_c !== 1'b1 || out_data_c !== 32'h6100) $display("FAIL ar_exit_c got v=%0b d=%h want v=1 d=6100", out_valid_c, out_data_c); else n_pass++;
                n_total++; if (out_valid_l !== 1'b1 || out_data_l !== 32'h6100) $display("FAIL ar_exit_l got v=%0b d=%h want v=1 d=6100", out_valid_l, out_data_l); else n_pass++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble_collapse();
        test_freeze();
        test_flush();
        test_flush_freeze();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
